data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 93 +++++++++
 rtl/data_mem_resp_fifo.sv | 80 ++++++++
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared memory-message definitions for the data memory responder:
//   - 4-byte request/response message structs and their widths
//   - type_ codes (READ = 0, WRITE = 1)
//   - legal range of the responder latency
//   - byte-lane helpers for sub-word reads and writes
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int REQ_W  = 77;
  localparam int RESP_W = 47;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Internal classification of an incoming request.
  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_BAD
  } opClass_e;

  function automatic opClass_e decodeOp(input logic [2:0] typeCode);
    opClass_e op;
    case (typeCode)
      MEM_TYPE_READ:  op = OP_READ;
      MEM_TYPE_WRITE: op = OP_WRITE;
      default:        op = OP_BAD;
    endcase
    return op;
  endfunction

  // A len field of zero means a full 4-byte access.
  function automatic logic [2:0] byteCount(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

  // Mask keeping the low n bytes of a word.
  function automatic logic [31:0] byteMask(input logic [2:0] n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = (i < int'(n)) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  // Read data: word shifted down by the byte offset, bytes beyond n cleared.
  function automatic logic [31:0] extractRead(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  n);
    return (word >> (8 * int'(off))) & byteMask(n);
  endfunction

  // Write merge: request bytes 0..n-1 land on word bytes off..off+n-1;
  // anything that would fall past byte 3 is dropped.
  function automatic logic [31:0] mergeWrite(input logic [31:0] oldWord,
                                             input logic [31:0] newData,
                                             input logic [1:0]  off,
                                             input logic [2:0]  n);
    logic [31:0] w;
    int src;
    w = oldWord;
    for (int i = 0; i < 4; i++) begin
      src = i - int'(off);
      if ((src >= 0) && (src < int'(n))) begin
        w[8*i +: 8] = newData[8*src +: 8];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/data_mem_resp_fifo.sv
// ---------------------------------------------------------------------------
// data_mem_resp_fifo
// Normal (non-bypass) FIFO holding finished responses until the consumer
// takes them. A pushed entry becomes visible on the output the cycle after
// the push. Async active-low reset empties the FIFO.
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   enqVal_i  push request (ignored when full)
//   enqMsg_i  entry to push
//   deqVal_o  head entry valid
//   deqRdy_i  consumer takes the head entry
//   deqMsg_o  head entry
// ---------------------------------------------------------------------------
module data_mem_resp_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 47
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enqVal_i,
  input  logic [p_width-1:0] enqMsg_i,
  output logic               deqVal_o,
  input  logic               deqRdy_i,
  output logic [p_width-1:0] deqMsg_o
);

  localparam int PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CntW = $clog2(p_depth + 1);

  logic [p_width-1:0] entries_q [p_depth];
  logic [PtrW-1:0]    wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]    rdPtr_q, rdPtr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               enqFire;
  logic               deqFire;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign enqFire  = enqVal_i && (cnt_q != CntW'(p_depth));
  assign deqVal_o = (cnt_q != '0);
  assign deqFire  = deqVal_o && deqRdy_i;
  assign deqMsg_o = entries_q[rdPtr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (enqFire) wrPtr_d = nextPtr(wrPtr_q);
    if (deqFire) rdPtr_d = nextPtr(rdPtr_q);
    case ({enqFire, deqFire})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state, cleared by reset so in-flight responses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (enqFire) entries_q[wrPtr_q] <= enqMsg_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Word-addressed data memory behind a valid/ready request/response pair.
// Reads and writes are resolved in the acceptance cycle, the response then
// travels a fixed latency pipeline into a response FIFO that absorbs
// consumer back-pressure. At most p_max_outst requests are in flight.
// Ports:
//   clk       clock
//   reset     asynchronous active-low reset
//   req_msg   request {type_, opaque, addr, len, data}
//   req_val   request valid
//   req_rdy   responder can accept a request
//   resp_msg  response {type_, opaque, test, len, data}
//   resp_val  response valid
//   resp_rdy  consumer accepts response
//   err       sticky: an unsupported request type was accepted
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int p_mem_nwords = 256,
  parameter int p_latency    = 2,
  parameter int p_max_outst  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  req_msg,
  input  logic              req_val,
  output logic              req_rdy,
  output logic [RESP_W-1:0] resp_msg,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic              err
);

  localparam int IdxW       = $clog2(p_mem_nwords);
  localparam int CntW       = $clog2(p_max_outst + 1);
  localparam int EffLatency = (p_latency < LATENCY_MIN) ? LATENCY_MIN :
                              (p_latency > LATENCY_MAX) ? LATENCY_MAX : p_latency;
  // The FIFO itself contributes one cycle of latency.
  localparam int PipeStages = EffLatency - 1;

  mem_req_4B_t     reqMsg;
  mem_resp_4B_t    newResp;
  mem_resp_4B_t    pushMsg;
  opClass_e        opClass;
  logic [IdxW-1:0] memIdx;
  logic [1:0]      byteOff;
  logic [2:0]      nBytes;
  logic [31:0]     rdWord;
  logic            reqFire;
  logic            respFire;
  logic            pushVal;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic [31:0]     mem_q [p_mem_nwords];
  logic            unusedAddrHi;

  assign reqMsg  = req_msg;
  assign opClass = decodeOp(reqMsg.type_);
  assign memIdx  = reqMsg.addr[2 +: IdxW];
  assign byteOff = reqMsg.addr[1:0];
  assign nBytes  = byteCount(reqMsg.len);
  assign rdWord  = mem_q[memIdx];

  // Address bits above the word index wrap around and are ignored.
  assign unusedAddrHi = ^reqMsg.addr[31:IdxW+2];

  // Gated by reset so the responder refuses requests while held in reset.
  assign req_rdy  = reset && (count_q < CntW'(p_max_outst));
  assign reqFire  = req_val && req_rdy;
  assign respFire = resp_val && resp_rdy;
  assign err      = err_q;

  // Build the response in the acceptance cycle; the read sees every write
  // committed at an earlier edge.
  always_comb begin
    newResp        = '0;
    newResp.type_  = reqMsg.type_;
    newResp.opaque = reqMsg.opaque;
    newResp.len    = reqMsg.len;
    if (opClass == OP_READ) begin
      newResp.data = extractRead(rdWord, byteOff, nBytes);
    end
  end

  // Storage is not reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (reqFire && (opClass == OP_WRITE)) begin
      mem_q[memIdx] <= mergeWrite(rdWord, reqMsg.data, byteOff, nBytes);
    end
  end

  // Fixed-latency pipeline between acceptance and the response FIFO; it
  // never stalls because the FIFO always has room for everything in flight.
  generate
    if (PipeStages == 0) begin : g_noPipe
      assign pushVal = reqFire;
      assign pushMsg = newResp;
    end else begin : g_pipe
      logic [PipeStages-1:0] val_q;
      mem_resp_4B_t          msg_q [PipeStages];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_q <= '0;
        end else begin
          val_q[0] <= reqFire;
          for (int s = 1; s < PipeStages; s++) val_q[s] <= val_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        msg_q[0] <= newResp;
        for (int s = 1; s < PipeStages; s++) msg_q[s] <= msg_q[s-1];
      end

      assign pushVal = val_q[PipeStages-1];
      assign pushMsg = msg_q[PipeStages-1];
    end
  endgenerate

  data_mem_resp_fifo #(
    .p_depth (p_max_outst),
    .p_width (RESP_W)
  ) u_respFifo (
    .clk      (clk),
    .rst_n    (reset),
    .enqVal_i (pushVal),
    .enqMsg_i (pushMsg),
    .deqVal_o (resp_val),
    .deqRdy_i (resp_rdy),
    .deqMsg_o (resp_msg)
  );

  // Outstanding count and sticky error next-state.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({reqFire, respFire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (reqFire && (opClass == OP_BAD)) err_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed-vector bench for data_mem_responder with hand-computed results.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int NWORDS = 256;
  localparam int LAT    = 2;
  localparam int MAXO   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [76:0] req_msg;
  logic        req_val;
  logic        req_rdy;
  logic [46:0] resp_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic        err;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .p_mem_nwords (NWORDS),
    .p_latency    (LAT),
    .p_max_outst  (MAXO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_msg  (req_msg),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .err      (err)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [76:0] mkReq(input logic [2:0] typ, input logic [7:0] opq,
                                        input logic [31:0] addr, input logic [1:0] len,
                                        input logic [31:0] data);
    return {typ, opq, addr, len, data};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until it is accepted.
  task automatic applyStimulus(input logic [2:0] typ, input logic [7:0] opq,
                               input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] data);
    int guard;
    req_msg = mkReq(typ, opq, addr, len, data);
    req_val = 1'b1;
    guard = 0;
    while (!req_rdy && guard < 50) begin
      tick();
      guard++;
    end
    if (guard == 50) checkOutput("reqRdyTimeout", {31'd0, req_rdy}, 32'd1);
    tick();
    req_val = 1'b0;
  endtask

  // Full transaction with resp_rdy high: returns the response and the
  // number of cycles from acceptance to resp_val.
  task automatic doTxn(input logic [2:0] typ, input logic [7:0] opq,
                       input logic [31:0] addr, input logic [1:0] len,
                       input logic [31:0] data,
                       output logic [46:0] rsp, output int lat);
    resp_rdy = 1'b1;
    applyStimulus(typ, opq, addr, len, data);
    lat = 1;
    while (!resp_val && lat < 20) begin
      tick();
      lat++;
    end
    rsp = resp_msg;
    tick();
  endtask

  initial begin
    logic [46:0] rsp;
    int          lat;
    int          acc;
    int          got;
    int          firstC;
    int          lastC;
    int          seen;
    logic        fireNow;
    logic        valNow;
    logic [46:0] rspNow;

    reset    = 1'b0;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rstReqRdy", {31'd0, req_rdy}, 32'd0);
    checkOutput("rstRespVal", {31'd0, resp_val}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("postRstReqRdy", {31'd0, req_rdy}, 32'd1);

    // Full-word write then read back, with latency check
    doTxn(3'd1, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF, rsp, lat);
    checkOutput("wrLatency", lat, LAT);
    checkOutput("wrData", rsp[31:0], 32'h0);
    checkOutput("wrType", {29'd0, rsp[46:44]}, 32'd1);
    doTxn(3'd0, 8'h5A, 32'h100, 2'd0, 32'h0, rsp, lat);
    checkOutput("rdLatency", lat, LAT);
    checkOutput("rdData", rsp[31:0], 32'hDEADBEEF);
    checkOutput("rdOpaque", {24'd0, rsp[43:36]}, 32'h5A);
    checkOutput("rdTest", {30'd0, rsp[35:34]}, 32'd0);
    checkOutput("rdType", {29'd0, rsp[46:44]}, 32'd0);

    // Sub-word writes and reads
    doTxn(3'd1, 8'h01, 32'h0, 2'd0, 32'h11223344, rsp, lat);
    doTxn(3'd1, 8'h02, 32'h2, 2'd1, 32'h000000AA, rsp, lat);
    doTxn(3'd0, 8'h03, 32'h0, 2'd0, 32'h0, rsp, lat);
    checkOutput("subRdFull", rsp[31:0], 32'h11AA3344);
    doTxn(3'd0, 8'h04, 32'h3, 2'd2, 32'h0, rsp, lat);
    checkOutput("subRdOff3Len2", rsp[31:0], 32'h00000011);
    checkOutput("subRdLen", {30'd0, rsp[33:32]}, 32'd2);
    doTxn(3'd0, 8'h05, 32'h1, 2'd3, 32'h0, rsp, lat);
    checkOutput("subRdOff1Len3", rsp[31:0], 32'h0011AA33);
    // Three bytes at offset 3: only the lowest byte fits in the word
    doTxn(3'd1, 8'h06, 32'h3, 2'd3, 32'h00CCBBDD, rsp, lat);
    doTxn(3'd0, 8'h07, 32'h0, 2'd0, 32'h0, rsp, lat);
    checkOutput("wrDiscardHigh", rsp[31:0], 32'hDDAA3344);

    // Address wrap-around
    doTxn(3'd1, 8'h08, 32'h8, 2'd0, 32'h5, rsp, lat);
    doTxn(3'd0, 8'h09, 4 * NWORDS + 32'h8, 2'd0, 32'h0, rsp, lat);
    checkOutput("wrapRd", rsp[31:0], 32'h5);
    doTxn(3'd0, 8'h0A, 32'h80000008, 2'd0, 32'h0, rsp, lat);
    checkOutput("wrapHighBit", rsp[31:0], 32'h5);

    // Unsupported type
    checkOutput("errBefore", {31'd0, err}, 32'd0);
    doTxn(3'd2, 8'h0B, 32'h100, 2'd0, 32'h12345678, rsp, lat);
    checkOutput("badData", rsp[31:0], 32'h0);
    checkOutput("badType", {29'd0, rsp[46:44]}, 32'd2);
    checkOutput("errSet", {31'd0, err}, 32'd1);
    doTxn(3'd0, 8'h0C, 32'h100, 2'd0, 32'h0, rsp, lat);
    checkOutput("badNoWrite", rsp[31:0], 32'hDEADBEEF);
    checkOutput("errSticky", {31'd0, err}, 32'd1);

    // Back-to-back full throughput
    resp_rdy = 1'b1;
    acc = 0; got = 0; firstC = -1; lastC = -1;
    for (int c = 0; c < 12; c++) begin
      if (acc < 6) begin
        req_msg = mkReq(3'd0, 8'(8'h30 + acc), 32'h100, 2'd0, 32'h0);
        req_val = 1'b1;
      end else begin
        req_val = 1'b0;
      end
      fireNow = req_val && req_rdy;
      valNow  = resp_val;
      rspNow  = resp_msg;
      @(posedge clk);
      if (fireNow) acc++;
      if (valNow) begin
        checkOutput("tputOpaque", {24'd0, rspNow[43:36]}, 32'h30 + got);
        if (firstC < 0) firstC = c;
        lastC = c;
        got++;
      end
      #1;
    end
    req_val = 1'b0;
    checkOutput("tputAccepted", acc, 6);
    checkOutput("tputResponses", got, 6);
    checkOutput("tputFirst", firstC, LAT);
    checkOutput("tputSpan", lastC - firstC, 5);

    // Back-pressure: outstanding limit and in-order release
    resp_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      req_msg = mkReq(3'd0, 8'(acc), 32'h100, 2'd0, 32'h0);
      req_val = 1'b1;
      fireNow = req_rdy;
      @(posedge clk);
      if (fireNow) acc++;
      #1;
    end
    req_val = 1'b0;
    checkOutput("bpAccepted", acc, MAXO);
    checkOutput("bpReqRdyLow", {31'd0, req_rdy}, 32'd0);
    checkOutput("bpHeadVal", {31'd0, resp_val}, 32'd1);
    checkOutput("bpHeadOpaque", {24'd0, resp_msg[43:36]}, 32'd0);
    resp_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < MAXO; c++) begin
      if (resp_val) begin
        checkOutput("bpOpaque", {24'd0, resp_msg[43:36]}, got);
        checkOutput("bpData", resp_msg[31:0], 32'hDEADBEEF);
        got++;
      end
      tick();
    end
    checkOutput("bpCount", got, MAXO);
    checkOutput("bpDrained", {31'd0, resp_val}, 32'd0);
    checkOutput("bpReqRdyBack", {31'd0, req_rdy}, 32'd1);

    // Reset with three responses outstanding
    resp_rdy = 1'b0;
    applyStimulus(3'd0, 8'hE0, 32'h0, 2'd0, 32'h0);
    applyStimulus(3'd0, 8'hE1, 32'h0, 2'd0, 32'h0);
    applyStimulus(3'd0, 8'hE2, 32'h0, 2'd0, 32'h0);
    repeat (3) tick();
    checkOutput("preRstVal", {31'd0, resp_val}, 32'd1);
    checkOutput("preRstErr", {31'd0, err}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midRstVal", {31'd0, resp_val}, 32'd0);
    checkOutput("midRstReqRdy", {31'd0, req_rdy}, 32'd0);
    checkOutput("midRstErr", {31'd0, err}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("relReqRdy", {31'd0, req_rdy}, 32'd1);
    resp_rdy = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_val) seen++;
      tick();
    end
    checkOutput("noStaleResp", seen, 0);
    doTxn(3'd0, 8'h21, 32'h0, 2'd0, 32'h0, rsp, lat);
    checkOutput("keptWord0", rsp[31:0], 32'hDDAA3344);
    checkOutput("keptLatency", lat, LAT);
    doTxn(3'd0, 8'h22, 32'h8, 2'd0, 32'h0, rsp, lat);
    checkOutput("keptWord2", rsp[31:0], 32'h5);
    checkOutput("errCleared", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
